mem_access_stage: RTL

Parametrised, handshaked successor to the fixed-latency memory pipeline stage. It sits between EX/MEM and WB and accepts one instruction at a time over a valid/ready interface. It issues loads and stores to a variable-latency data memory over a request/response port, supporting byte, half, word and double-word accesses with byte enables and sign/zero extension. It presents the write-back bundle to WB over a second valid/ready interface, with flush and misalignment handling.

---
 rtl/mem_access_stage_pkg.sv | 31 +++
 rtl/mem_access_stage_align.sv | 50 +++++
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, stage states
// and the alignment check used when an instruction is accepted.
package mem_access_stage_pkg;

  localparam int DEF_PC_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_e;

  // An access wider than the data path is illegal and reported like a misaligned one.
  function automatic logic is_misaligned(input logic [2:0] addr_low,
                                         input logic [1:0] size,
                                         input int         nb);
    logic [3:0] bytes;
    bytes = 4'd1 << size;
    return (int'(bytes) > nb) || ((addr_low & (bytes[2:0] - 3'd1)) != 3'd0);
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Lane alignment: store data shift and byte enables, load extract and
// sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int LANE_W     = $clog2(NB)
) (
  input  logic [LANE_W-1:0]     lane,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] wdata_lane,
  output logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [DATA_WIDTH-1:0] rshift;
  logic                  sign;
  logic                  fill;

  assign wdata_lane = wdata << {lane, 3'b000};
  assign rshift     = rdata >> {lane, 3'b000};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << size));
    end
  end

  always_comb begin
    sign = 1'b0;
    unique case (size)
      MEM_SIZE_B: sign = rshift[7];
      MEM_SIZE_H: sign = rshift[15];
      MEM_SIZE_W: sign = rshift[31];
      default:    sign = rshift[DATA_WIDTH-1];
    endcase
    fill      = sign & ~is_unsigned;
    rdata_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rdata_ext[i] = (i < (8 << size)) ? rshift[i] : fill;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Handshaked memory-access stage between EX/MEM and WB: issues loads/stores to a
// variable-latency memory and presents a registered write-back bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PC_WIDTH       = DEF_PC_WIDTH,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mem_read,
  input  logic                        in_mem_write,
  input  logic [1:0]                  in_size,
  input  logic                        in_unsigned,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_wdata,
  input  logic [DATA_WIDTH-1:0]       in_alu_res,
  input  logic [DATA_WIDTH-1:0]       in_imm,
  input  logic [REG_ADDR_WIDTH-1:0]   in_reg_dst,
  input  logic [PC_WIDTH-1:0]         in_next_pc,
  input  logic [1:0]                  in_wb_sel,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [DATA_WIDTH-1:0]       mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]     mem_req_be,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]       mem_rsp_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_wb_sel,
  output logic [DATA_WIDTH-1:0]       out_mem_data,
  output logic [DATA_WIDTH-1:0]       out_alu_res,
  output logic [DATA_WIDTH-1:0]       out_imm,
  output logic [REG_ADDR_WIDTH-1:0]   out_reg_dst,
  output logic [PC_WIDTH-1:0]         out_next_pc,
  output logic                        out_misaligned
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);

  mem_state_e            state_q, state_d, accept_state;
  logic                  op_store_q;
  logic                  killed_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  in_is_mem;
  logic                  in_mis;
  logic                  req_active;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_ready  = !rst && !flush &&
                     (state_q == ST_IDLE || (state_q == ST_OUT && out_ready));
  assign accept    = in_valid && in_ready;
  assign in_is_mem = in_mem_read || in_mem_write;
  assign in_mis    = is_misaligned(in_addr[2:0], in_size, NB);

  assign accept_state = (!in_is_mem || in_mis) ? ST_OUT : ST_REQ;

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .lane        (addr_q[LANE_W-1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .rdata       (mem_rsp_rdata),
    .wdata_lane  (wdata_lane),
    .be          (be),
    .rdata_ext   (load_data)
  );

  // The request command is driven only in REQ so every output reads 0 out of reset.
  assign req_active    = (state_q == ST_REQ);
  assign mem_req_valid = req_active;
  assign mem_req_we    = req_active && op_store_q;
  assign mem_req_addr  = req_active ? {addr_q[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_req_wdata = req_active ? wdata_lane : '0;
  assign mem_req_be    = req_active ? be : '0;
  assign out_valid     = (state_q == ST_OUT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = accept_state;
      ST_REQ: begin
        // A flushed store is still committed; a flushed load must drain its response.
        if (mem_req_ready) begin
          if (op_store_q) state_d = (killed_q || flush) ? ST_IDLE : ST_OUT;
          else            state_d = (killed_q || flush) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush)              state_d = mem_rsp_valid ? ST_IDLE : ST_DRAIN;
        else if (mem_rsp_valid) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (flush)          state_d = ST_IDLE;
        else if (out_ready) state_d = accept ? accept_state : ST_IDLE;
      end
      ST_DRAIN: if (mem_rsp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_store_q     <= 1'b0;
      killed_q       <= 1'b0;
      size_q         <= '0;
      unsigned_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      out_wb_sel     <= '0;
      out_mem_data   <= '0;
      out_alu_res    <= '0;
      out_imm        <= '0;
      out_reg_dst    <= '0;
      out_next_pc    <= '0;
      out_misaligned <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_store_q     <= in_mem_write && !in_mem_read;
        killed_q       <= 1'b0;
        size_q         <= in_size;
        unsigned_q     <= in_unsigned;
        addr_q         <= in_addr;
        wdata_q        <= in_wdata;
        out_wb_sel     <= in_wb_sel;
        out_mem_data   <= '0;
        out_alu_res    <= in_alu_res;
        out_imm        <= in_imm;
        out_reg_dst    <= in_reg_dst;
        out_next_pc    <= in_next_pc;
        out_misaligned <= in_is_mem && in_mis;
      end else begin
        if (state_q == ST_REQ && flush) killed_q <= 1'b1;
        if (state_q == ST_WAIT && mem_rsp_valid && !flush) out_mem_data <= load_data;
      end
    end
  end

endmodule
